sha256_msg_padder: RTL and testbench

// - Upstream feeder for the SHA-256 compression core: accepts a message as a byte stream and emits

---
 rtl/sha256_msg_padder.sv | 164 ++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// Byte-stream to SHA-256 block padder: appends 0x80, zero fill and the 64-bit bit length.
// Optional SHA256_PAD_OVF_EN adds a sticky len_ovf flag and saturates the byte counter.
module sha256_msg_padder #(
    parameter int CNT_W = 61
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_keep,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_block,
    output logic         out_first,
    output logic         out_last
`ifdef SHA256_PAD_OVF_EN
    ,
    output logic         len_ovf
`endif
);

    typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT, S_EXTRA} state_t;

    state_t           state_reg, state_next;
    logic [6:0]       byte_idx_reg;
    logic [CNT_W-1:0] byte_cnt_reg;
    logic             first_pend_reg, extra_pend_reg, extra_mark_reg;
    logic             init_reg, out_last_reg;
    logic [511:0]     out_block_reg;
    logic [7:0]       buf_reg [64];
    logic [63:0][7:0] full_blk, pad_blk, extra_blk;
    logic [63:0]      len_bits;
    logic             accept, store, cnt_sat, idx_full, out_fire;

    assign accept   = in_valid && in_ready;
`ifdef SHA256_PAD_OVF_EN
    logic len_ovf_reg;
    assign cnt_sat  = &byte_cnt_reg;
    assign len_ovf  = len_ovf_reg;
`else
    assign cnt_sat  = 1'b0;
`endif
    assign store    = accept && in_keep && !cnt_sat;
    assign idx_full = store && (byte_idx_reg == 7'd63);
    assign out_fire = out_valid && out_ready;
    assign len_bits = 64'(byte_cnt_reg) << 3;

    // in_ready stays low until the first clock after reset release
    assign in_ready  = init_reg && (state_reg == S_FILL);
    assign out_valid = (state_reg == S_EMIT);
    assign out_first = out_valid && first_pend_reg;
    assign out_last  = out_last_reg;
    assign out_block = out_block_reg;

    // Per-byte lanes; packed element 63 is message byte 0 (MSB of out_block)
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_lane
            localparam logic [6:0] IDX = 7'(gi);
            always_ff @(posedge clk) begin
                if (store && byte_idx_reg == IDX)
                    buf_reg[gi] <= in_data;
            end
            assign full_blk[63-gi] = (store && byte_idx_reg == IDX) ? in_data : buf_reg[gi];
            if (gi >= 56) begin : g_len
                assign pad_blk[63-gi] = (IDX < byte_idx_reg)     ? buf_reg[gi] :
                                        (IDX == byte_idx_reg)    ? 8'h80 :
                                        (byte_idx_reg <= 7'd55)  ? len_bits[8*(63-gi) +: 8] : 8'h00;
                assign extra_blk[63-gi] = len_bits[8*(63-gi) +: 8];
            end else begin : g_body
                assign pad_blk[63-gi] = (IDX < byte_idx_reg)  ? buf_reg[gi] :
                                        (IDX == byte_idx_reg) ? 8'h80 : 8'h00;
                if (gi == 0) begin : g_mark
                    assign extra_blk[63] = extra_mark_reg ? 8'h80 : 8'h00;
                end else begin : g_zero
                    assign extra_blk[63-gi] = 8'h00;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= S_FILL;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FILL: begin
                if (accept && in_last)      state_next = S_PAD;
                else if (idx_full)          state_next = S_EMIT;
            end
            S_PAD:   state_next = S_EMIT;
            S_EMIT: begin
                if (out_fire)
                    state_next = (!out_last_reg && extra_pend_reg) ? S_EXTRA : S_FILL;
            end
            S_EXTRA: state_next = S_EMIT;
            default: state_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_reg       <= 1'b0;
            byte_idx_reg   <= '0;
            byte_cnt_reg   <= '0;
            first_pend_reg <= 1'b1;
            extra_pend_reg <= 1'b0;
            extra_mark_reg <= 1'b0;
            out_last_reg   <= 1'b0;
            out_block_reg  <= '0;
`ifdef SHA256_PAD_OVF_EN
            len_ovf_reg    <= 1'b0;
`endif
        end else begin
            init_reg <= 1'b1;
            case (state_reg)
                S_FILL: begin
                    if (store) begin
                        byte_idx_reg <= (idx_full && !in_last) ? 7'd0 : byte_idx_reg + 7'd1;
                        byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
                    end
`ifdef SHA256_PAD_OVF_EN
                    if (accept && in_keep && cnt_sat)
                        len_ovf_reg <= 1'b1;
`endif
                    if (idx_full && !in_last) begin
                        out_block_reg <= full_blk;
                        out_last_reg  <= 1'b0;
                    end
                end
                S_PAD: begin
                    out_block_reg  <= pad_blk;
                    out_last_reg   <= (byte_idx_reg <= 7'd55);
                    extra_pend_reg <= (byte_idx_reg > 7'd55);
                    extra_mark_reg <= (byte_idx_reg == 7'd64);
                end
                S_EMIT: begin
                    if (out_fire) begin
                        first_pend_reg <= out_last_reg;
                        if (out_last_reg) begin
                            byte_cnt_reg <= '0;
                            byte_idx_reg <= '0;
`ifdef SHA256_PAD_OVF_EN
                            len_ovf_reg  <= 1'b0;
`endif
                        end
                    end
                end
                S_EXTRA: begin
                    out_block_reg  <= extra_blk;
                    out_last_reg   <= 1'b1;
                    extra_pend_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: a queue-based padding model predicts every block.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0, in_keep = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         in_ready, out_valid, out_first, out_last;
    logic [511:0] out_block;

    sha256_msg_padder dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .out_first(out_first), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [511:0] blk; logic first; logic last; } exp_t;

    exp_t         exp_q[$];
    int           checks = 0, errors = 0, stall_req = 0, blk_no = 0;
    bit           in_reset = 1'b0, prev_stalled = 1'b0;
    logic [511:0] held_blk, last_blk;
    logic         held_first, held_last;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Standard padding on the whole message, then cut into 64-byte blocks
    task automatic model(input bq_t msg);
        bq_t         p;
        logic [63:0] bits;
        exp_t        e;
        int          nb;
        p    = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 64; i++) e.blk[511-8*i -: 8] = p[64*b+i];
            e.first = (b == 0);
            e.last  = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic put_beat(input logic [7:0] d, input logic k, input logic l);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
        #1;
        while (!in_ready && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) chk("in_ready_timeout", 512'(in_ready), 512'd1);
        else @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
    endtask

    task automatic send(input bq_t msg, input int skip_at);
        model(msg);
        if (msg.size() == 0) put_beat(8'h00, 1'b0, 1'b1);
        else begin
            for (int i = 0; i < msg.size(); i++) begin
                if (i == skip_at) put_beat(8'hA5, 1'b0, 1'b0);
                put_beat(msg[i], 1'b1, (i == msg.size() - 1));
            end
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk); n++;
        end
        chk({name, "_drain"}, 512'(exp_q.size()), 512'd0);
        @(negedge clk);
    endtask

    // Output side: drives out_ready, checks stall stability and every transferred block
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (in_reset || !reset_n) begin
                prev_stalled = 1'b0;
                out_ready    = 1'b1;
            end else begin
                if (prev_stalled) begin
                    chk("stall_valid", 512'(out_valid), 512'd1);
                    chk("stall_block", out_block, held_blk);
                    chk("stall_first", 512'(out_first), 512'(held_first));
                    chk("stall_last", 512'(out_last), 512'(held_last));
                    chk("stall_in_ready", 512'(in_ready), 512'd0);
                end
                if (out_valid && stall_req > 0) begin
                    out_ready = 1'b0;
                    stall_req--;
                end else out_ready = 1'b1;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_block", 512'd1, 512'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("blk", out_block, e.blk);
                        chk("first", 512'(out_first), 512'(e.first));
                        chk("last", 512'(out_last), 512'(e.last));
                    end
                    last_blk = out_block;
                    $display("block %0d first=%0b last=%0b data=%0h", blk_no, out_first, out_last, out_block);
                    blk_no++;
                end
                prev_stalled = out_valid && !out_ready;
                held_blk     = out_block;
                held_first   = out_first;
                held_last    = out_last;
            end
        end
    end

    initial begin
        bq_t m;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 512'(out_valid), 512'd0);
        chk("rst_in_ready", 512'(in_ready), 512'd0);
        chk("rst_out_block", out_block, 512'd0);
        chk("rst_out_first", 512'(out_first), 512'd0);
        chk("rst_out_last", 512'(out_last), 512'd0);
        reset_n = 1'b1;

        m = '{8'h61, 8'h62, 8'h63};
        send(m, -1); drain("abc");
        chk("abc_lit", last_blk, {32'h61626380, 416'd0, 64'h18});

        m.delete();
        send(m, -1); drain("empty");
        chk("empty_lit", last_blk, {8'h80, 440'd0, 64'd0});

        m.delete(); for (int i = 0; i < 55; i++) m.push_back(8'h00);
        send(m, -1); drain("len55");
        chk("len55_lit", last_blk, {440'd0, 8'h80, 64'h1B8});

        m.delete(); for (int i = 0; i < 56; i++) m.push_back(8'h00);
        send(m, -1); drain("len56");
        chk("len56_lit", last_blk, {448'd0, 64'h1C0});

        m.delete(); for (int i = 0; i < 64; i++) m.push_back(8'(i));
        send(m, -1); drain("len64");
        chk("len64_lit", last_blk, {8'h80, 440'd0, 64'h200});

        stall_req = 10;
        m.delete(); for (int i = 0; i < 100; i++) m.push_back(8'(i * 3 + 1));
        send(m, 30); drain("stall100");
        chk("stall_consumed", 512'(stall_req), 512'd0);

        m.delete(); for (int i = 0; i < 119; i++) m.push_back(8'(255 - i));
        send(m, -1); drain("len119");
        m.delete(); for (int i = 0; i < 120; i++) m.push_back(8'(i ^ 8'h5A));
        send(m, 7); drain("len120");

        stall_req = 1000;
        m = '{8'h61, 8'h62, 8'h63};
        send(m, -1);
        repeat (4) @(negedge clk);
        chk("emit_before_rst", 512'(out_valid), 512'd1);
        #2;
        in_reset = 1'b1;
        reset_n  = 1'b0;
        #1;
        chk("rst_mid_valid", 512'(out_valid), 512'd0);
        chk("rst_mid_block", out_block, 512'd0);
        exp_q.delete();
        @(negedge clk); @(negedge clk);
        stall_req = 0;
        reset_n   = 1'b1;
        in_reset  = 1'b0;
        send(m, -1); drain("abc_after_rst");
        chk("abc_after_rst_lit", last_blk, {32'h61626380, 416'd0, 64'h18});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
